// File: rtl/srt_divider_param.sv
// Radix-2 SRT iterative divider, signed/unsigned, fixed latency WIDTH+2.
// Redundant quotient digits {-1,0,+1} are resolved in a single correction cycle.
module srt_divider_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int W  = WIDTH;
  localparam int SW = $clog2(W);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] NORM = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] CORR = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [2:0]    state;
  logic          smode;
  logic [W-1:0]  a, b;
  logic [W+1:0]  p;
  logic [W-1:0]  x, d, qp, qn;
  logic [SW-1:0] sh, cnt;
  logic          negq, negr, dz, ov;

  logic [W-1:0]   am, bm, dn;
  logic [SW-1:0]  nsh;
  logic [2*W-1:0] r2;

  assign am = (smode && a[W-1]) ? -a : a;
  assign bm = (smode && b[W-1]) ? -b : b;

  always_comb begin
    nsh = '0;
    for (int i = 0; i < W; i++)
      if (bm[i]) nsh = SW'(W - 1 - i);
  end

  // Scaling the dividend by the same shift keeps the integer quotient
  // and leaves the remainder scaled by 2^sh.
  assign dn = bm << nsh;
  assign r2 = {{W{1'b0}}, am} << nsh;

  logic [W+1:0] t, pn;
  logic         qpos, qneg;

  assign t    = {p[W:0], x[W-1]};
  assign qpos = !t[W+1] && (t[W] || t[W-1]);
  assign qneg = t[W+1] && !(t[W] && t[W-1]);
  assign pn   = qpos ? t - {2'b00, d} :
                qneg ? t + {2'b00, d} : t;

  logic          pneg;
  logic [W-1:0]  rc, qf, rmag, qs, rs;

  assign pneg = p[W+1];
  assign rc   = p[W-1:0] + (pneg ? d : '0);
  assign qf   = qp - qn - W'(pneg);
  assign rmag = rc >> sh;
  assign qs   = negq ? -qf : qf;
  assign rs   = negr ? -rmag : rmag;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == NORM) || (state == ITER) || (state == CORR);
  assign valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      smode       <= 1'b0;
      a           <= '0;
      b           <= '0;
      p           <= '0;
      x           <= '0;
      d           <= '0;
      qp          <= '0;
      qn          <= '0;
      sh          <= '0;
      cnt         <= '0;
      negq        <= 1'b0;
      negr        <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE) || (state == DONE): begin
          if (start) begin
            smode <= signed_mode;
            a     <= dividend;
            b     <= divisor;
            state <= NORM;
          end else begin
            state <= IDLE;
          end
        end
        state == NORM: begin
          negq  <= smode && (a[W-1] ^ b[W-1]);
          negr  <= smode && a[W-1];
          dz    <= (b == '0);
          ov    <= smode && (a == MINV) && (b == '1);
          d     <= dn;
          p     <= {2'b00, r2[2*W-1:W]};
          x     <= r2[W-1:0];
          sh    <= nsh;
          cnt   <= '0;
          qp    <= '0;
          qn    <= '0;
          state <= ITER;
        end
        state == ITER: begin
          p   <= pn;
          x   <= x << 1;
          qp  <= {qp[W-2:0], qpos};
          qn  <= {qn[W-2:0], qneg};
          cnt <= cnt + 1'b1;
          if (cnt == SW'(W - 1)) state <= CORR;
        end
        state == CORR: begin
          quotient    <= dz ? '1 : ov ? MINV : qs;
          remainder   <= dz ? a : ov ? '0 : rs;
          div_by_zero <= dz;
          overflow    <= ov && !dz;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
